pc_fetch_decode: RTL and testbench
==================================

# pc_fetch_decode

Fetch-address generator and instruction decoder for the five-stage ARM-subset pipeline. A 32-bit program counter advances by 4 through a dedicated incrementer. A combinational control unit decodes the 32-bit instruction held in IF/ID into the control word consumed by the CU mux and the ID/EXE register. The PC drives the instruction ROM address; the decoded fields feed downstream stages unchanged.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears PC.
- pc_en  in  1  PC load enable; 1 = advance, 0 = hold (stall).
- instruction  in  32  instruction from IF/ID register.
- pc_out  out  32  current PC (ROM uses [7:0]).
- pc_plus4  out  32  pc_out + 4.
- am  out  2  addressing mode.
- rf_en  out  1  register-file write enable.
- alu_op  out  4  ALU operation.
- load  out  1  load instruction.
- branch_link  out  1  branch (B/BL).
- s_bit  out  1  update flags.
- rw  out  1  data memory direction: 0 read, 1 write.
- size  out  1  0 word, 1 byte.
- datamem_en  out  1  data memory enable.

## Operation
- PC: on clk rise, reset=1 -> pc_out=0; else pc_en=1 -> pc_out=pc_plus4; else hold. Reset dominates pc_en.
- Incrementer: pc_plus4 = pc_out + 4 mod 2^32; no carry out. 0xFFFFFFFC wraps to 0.
- Decoder is purely combinational. Condition field [31:28] is ignored; evaluation happens elsewhere.
- instruction == 0 (NOP): all control outputs 0.
- Data processing, [27:26]=00:
  - alu_op = [24:21]; s_bit = [20].
  - rf_en = 1, except opcodes 1000–1011 (TST/TEQ/CMP/CMN) -> 0.
  - am = 00 if [25]=1 (rotated immediate); else 01 (shifted register).
  - load, branch_link, datamem_en, rw, size = 0.
- Load/store, [27:26]=01:
  - datamem_en = 1; load = L[20]; rf_en = L[20]; rw = ~L[20]; size = B[22].
  - alu_op = 0100 (add) if U[23]=1, else 0010 (sub).
  - am = 10 if [25]=0 (12-bit immediate offset); else 11 (register offset).
  - s_bit, branch_link = 0.
- Branch, [27:25]=101:
  - branch_link = 1; rf_en = L[24] (BL writes LR).
  - alu_op = 0000; am = 00; all other outputs 0.
- Any other encoding: all control outputs 0.

## Timing
- PC is the only state. Decode outputs and pc_plus4 settle combinationally in the same cycle.
- Reset value: pc_out = 0, so pc_plus4 = 4 during reset. Control outputs depend only on instruction.
- Deassert reset -> first rising edge with pc_en=1 gives pc_out = 4, then 8, 12, … one step per enabled edge.
- pc_en toggling mid-stream: held value persists exactly while pc_en=0.
- Reset asserted mid-run -> pc_out = 0 at the next edge regardless of pc_en.
- No handshakes.

## Structure
- Shared package holds:
  - opcode constants: AND=0000, SUB=0010, ADD=0100, TST..CMN=1000..1011.
  - am encodings 00/01/10/11.
  - instruction-class field positions.
- Sub-modules:
  - pc_reg: PC register.
  - pc_adder: +4 incrementer.
  - control_decoder: combinational decode.
- Top instantiates all three and wires the incrementer output back into the PC input.

## Test plan
- Reset and step: reset=1 for 1 edge, then pc_en=1 for 5 edges -> pc_out 0, 4, 8, 12, 16, 20; pc_plus4 always pc_out+4.
- Stall: pc_en=0 for 2 edges at pc_out=12 -> holds 12; re-enable -> 16. Reset with pc_en=1 -> 0 next edge.
- ANDS (0xE2110000):
  - am=00, s_bit=1, rf_en=1, alu_op=0000.
  - datamem_en=0, load=0, branch_link=0.
- AND (0xE2010000): same as ANDS but s_bit=0. CMP imm (0xE3510000): rf_en=0, s_bit=1, alu_op=1010.
- LDRB (0xE7D12000):
  - am=11, datamem_en=1, rw=0, size=1, load=1, rf_en=1, alu_op=0100, s_bit=0.
  - STR imm (0xE5812000): am=10, rw=1, size=0, load=0, rf_en=0.
- BNE (0x1AFFFFFD): branch_link=1, rf_en=0, datamem_en=0. BL (0xEB000000): branch_link=1, rf_en=1. NOP (0x00000000): all control outputs 0.

Source files
------------

// File: rtl/pc_fetch_decode_pkg.sv
// Shared constants and types for the fetch-address generator and instruction decoder.
package pc_fetch_decode_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;

  typedef enum logic [1:0] {
    AM_IMM_ROT = 2'b00,
    AM_SHF_REG = 2'b01,
    AM_LS_IMM  = 2'b10,
    AM_LS_REG  = 2'b11
  } am_e;

  // Instruction field positions
  localparam int CLS_HI   = 27;
  localparam int CLS_LO   = 26;
  localparam int I_BIT    = 25;
  localparam int OPC_HI   = 24;
  localparam int OPC_LO   = 21;
  localparam int LINK_BIT = 24;
  localparam int U_BIT    = 23;
  localparam int B_BIT    = 22;
  localparam int L_BIT    = 20;
  localparam int S_BIT    = 20;

  localparam logic [1:0] CLS_DP = 2'b00;
  localparam logic [1:0] CLS_LS = 2'b01;
  localparam logic [2:0] CLS_BR = 3'b101;

  typedef struct packed {
    am_e        am;
    logic       rf_en;
    logic [3:0] alu_op;
    logic       load;
    logic       branch_link;
    logic       s_bit;
    logic       rw;
    logic       size;
    logic       datamem_en;
  } ctrl_t;

endpackage

// File: rtl/pc_fetch_decode_if.sv
// Bus between the fetch/decode block and its driver: PC enable, instruction in, PC and control out.
interface pc_fetch_decode_if;
  import pc_fetch_decode_pkg::*;

  logic        pc_en;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  am_e         am;
  logic        rf_en;
  logic [3:0]  alu_op;
  logic        load;
  logic        branch_link;
  logic        s_bit;
  logic        rw;
  logic        size;
  logic        datamem_en;

  modport master (
    output pc_en, instruction,
    input  pc_out, pc_plus4, am, rf_en, alu_op, load, branch_link,
           s_bit, rw, size, datamem_en
  );

  modport slave (
    input  pc_en, instruction,
    output pc_out, pc_plus4, am, rf_en, alu_op, load, branch_link,
           s_bit, rw, size, datamem_en
  );
endinterface

// File: rtl/pc_fetch_decode_control_decoder.sv
// Combinational control unit; the condition field is ignored here and evaluated downstream.
module control_decoder
  import pc_fetch_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);
  logic [3:0] opc;
  assign opc = instr_i[OPC_HI:OPC_LO];

  always_comb begin
    ctrl_o = '0;
    // An all-zero word would otherwise decode as AND r0,r0,r0 and write the RF
    if (instr_i != '0) begin
      if (instr_i[CLS_HI:CLS_LO] == CLS_DP) begin
        ctrl_o.alu_op = opc;
        ctrl_o.s_bit  = instr_i[S_BIT];
        ctrl_o.rf_en  = !(opc inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN});
        ctrl_o.am     = instr_i[I_BIT] ? AM_IMM_ROT : AM_SHF_REG;
      end else if (instr_i[CLS_HI:CLS_LO] == CLS_LS) begin
        ctrl_o.datamem_en = 1'b1;
        ctrl_o.load       = instr_i[L_BIT];
        ctrl_o.rf_en      = instr_i[L_BIT];
        ctrl_o.rw         = ~instr_i[L_BIT];
        ctrl_o.size       = instr_i[B_BIT];
        ctrl_o.alu_op     = instr_i[U_BIT] ? OP_ADD : OP_SUB;
        ctrl_o.am         = instr_i[I_BIT] ? AM_LS_REG : AM_LS_IMM;
      end else if (instr_i[CLS_HI:I_BIT] == CLS_BR) begin
        ctrl_o.branch_link = 1'b1;
        ctrl_o.rf_en       = instr_i[LINK_BIT];
      end
    end
  end
endmodule

// File: rtl/pc_fetch_decode_pc_adder.sv
// Dedicated +4 incrementer; wraps modulo 2^32 with no carry out.
module pc_adder (
  input  logic [31:0] a_i,
  output logic [31:0] sum_o
);
  assign sum_o = a_i + 32'd4;
endmodule

// File: rtl/pc_fetch_decode_pc_reg.sv
// Program counter register: synchronous reset to 0, loads d_i when enabled, else holds.
module pc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) pc_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign q_o = pc_q;
endmodule

// File: rtl/pc_fetch_decode.sv
// Fetch/decode top: PC register fed back through the +4 incrementer, plus the control decoder.
module pc_fetch_decode
  import pc_fetch_decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  pc_fetch_decode_if.slave bus
);
  logic [31:0] pc, pc_nxt;
  ctrl_t       ctrl;

  pc_reg u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (bus.pc_en),
    .d_i   (pc_nxt),
    .q_o   (pc)
  );

  pc_adder u_pc_adder (
    .a_i   (pc),
    .sum_o (pc_nxt)
  );

  control_decoder u_dec (
    .instr_i (bus.instruction),
    .ctrl_o  (ctrl)
  );

  assign bus.pc_out      = pc;
  assign bus.pc_plus4    = pc_nxt;
  assign bus.am          = ctrl.am;
  assign bus.rf_en       = ctrl.rf_en;
  assign bus.alu_op      = ctrl.alu_op;
  assign bus.load        = ctrl.load;
  assign bus.branch_link = ctrl.branch_link;
  assign bus.s_bit       = ctrl.s_bit;
  assign bus.rw          = ctrl.rw;
  assign bus.size        = ctrl.size;
  assign bus.datamem_en  = ctrl.datamem_en;
endmodule

// File: tb/tb_pc_fetch_decode.sv
// Directed bench for pc_fetch_decode: decode vector table plus PC step/stall/reset sequences.
module tb_pc_fetch_decode;
  import pc_fetch_decode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_fetch_decode_if bus ();

  pc_fetch_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Standalone incrementer for the wrap boundary, unreachable by stepping the PC
  logic [31:0] wrap_a, wrap_s;
  pc_adder u_wrap (.a_i(wrap_a), .sum_o(wrap_s));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp_pc);
    check({name, ".pc_out"},   bus.pc_out,   exp_pc);
    check({name, ".pc_plus4"}, bus.pc_plus4, exp_pc + 32'd4);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic ctrl_t mk(am_e am, logic rf, logic [3:0] alu, logic ld, logic bl,
                               logic s, logic rw, logic sz, logic dm);
    ctrl_t c;
    c.am = am; c.rf_en = rf; c.alu_op = alu; c.load = ld; c.branch_link = bl;
    c.s_bit = s; c.rw = rw; c.size = sz; c.datamem_en = dm;
    return c;
  endfunction

  initial begin
    //                        am          rf  alu      ld  bl  s   rw  sz  dm
    vecs.push_back('{"ANDS",    32'hE2110000, mk(AM_IMM_ROT, 1, 4'b0000, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{"AND",     32'hE2010000, mk(AM_IMM_ROT, 1, 4'b0000, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"CMPimm",  32'hE3510000, mk(AM_IMM_ROT, 0, 4'b1010, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{"SUBreg",  32'hE0421003, mk(AM_SHF_REG, 1, 4'b0010, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"TSTreg",  32'hE1100001, mk(AM_SHF_REG, 0, 4'b1000, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{"LDRB",    32'hE7D12000, mk(AM_LS_REG,  1, 4'b0100, 1, 0, 0, 0, 1, 1)});
    vecs.push_back('{"STRimm",  32'hE5812000, mk(AM_LS_IMM,  0, 4'b0100, 0, 0, 0, 1, 0, 1)});
    vecs.push_back('{"STRneg",  32'hE5012004, mk(AM_LS_IMM,  0, 4'b0010, 0, 0, 0, 1, 0, 1)});
    vecs.push_back('{"BNE",     32'h1AFFFFFD, mk(AM_IMM_ROT, 0, 4'b0000, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"BL",      32'hEB000000, mk(AM_IMM_ROT, 1, 4'b0000, 0, 1, 0, 0, 0, 0)});
    vecs.push_back('{"NOP",     32'h00000000, mk(AM_IMM_ROT, 0, 4'b0000, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"LDM",     32'hE8BD0000, mk(AM_IMM_ROT, 0, 4'b0000, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"COPROC",  32'hEE000000, mk(AM_IMM_ROT, 0, 4'b0000, 0, 0, 0, 0, 0, 0)});

    reset = 1'b1;
    bus.pc_en = 1'b0;
    bus.instruction = 32'h0;
    wrap_a = 32'hFFFF_FFFC;

    // Reset, then five enabled edges
    edge_step();
    check_pc("reset", 32'd0);
    reset = 1'b0;
    bus.pc_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      edge_step();
      check_pc($sformatf("step%0d", i), 32'(i * 4));
    end

    // Stall at 12
    reset = 1'b1;
    edge_step();
    check_pc("reset_mid_en", 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) edge_step();
    check_pc("pre_stall", 32'd12);
    bus.pc_en = 1'b0;
    edge_step();
    check_pc("stall1", 32'd12);
    edge_step();
    check_pc("stall2", 32'd12);
    bus.pc_en = 1'b1;
    edge_step();
    check_pc("resume", 32'd16);

    // Reset dominates even when pc_en is low
    bus.pc_en = 1'b0;
    reset = 1'b1;
    edge_step();
    check_pc("reset_no_en", 32'd0);
    reset = 1'b0;
    edge_step();
    check_pc("hold_after_reset", 32'd0);

    check("wrap", wrap_s, 32'h0000_0000);

    // Decode table, with PC stepping to show decode is independent of it
    bus.pc_en = 1'b1;
    foreach (vecs[i]) begin
      bus.instruction = vecs[i].instr;
      edge_step();
      check({"dec_", vecs[i].name},
            32'({bus.am, bus.rf_en, bus.alu_op, bus.load, bus.branch_link,
                 bus.s_bit, bus.rw, bus.size, bus.datamem_en}),
            32'(vecs[i].exp));
    end
    check_pc("pc_after_decode", 32'(vecs.size() * 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
